// File: rtl/axi_ram_responder.sv
// AXI4 subordinate backed by a word-wide internal RAM: one write burst and one read burst
// in flight at a time, with fully independent read and write channels.
module axi_ram_responder #(
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned M_AXI_ID_W = 6,
    parameter int unsigned AXI_STRB_W = 8,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M_AXI_ID_W-1:0] memory_axi_aw_awid,
    input  logic [AXI_ADDR_W-1:0] memory_axi_aw_awaddr,
    input  logic [7:0]            memory_axi_aw_awlen,
    input  logic [1:0]            memory_axi_aw_awburst,
    input  logic                  memory_axi_aw_awvalid,
    output logic                  memory_axi_aw_awready,
    input  logic [AXI_DATA_W-1:0] memory_axi_w_wdata,
    input  logic [AXI_STRB_W-1:0] memory_axi_w_wstrb,
    input  logic                  memory_axi_w_wlast,
    input  logic                  memory_axi_w_wvalid,
    output logic                  memory_axi_w_wready,
    output logic [M_AXI_ID_W-1:0] memory_axi_b_bid,
    output logic [2:0]            memory_axi_b_bresp,
    output logic                  memory_axi_b_bvalid,
    input  logic                  memory_axi_b_bready,
    input  logic [M_AXI_ID_W-1:0] memory_axi_ar_arid,
    input  logic [AXI_ADDR_W-1:0] memory_axi_ar_araddr,
    input  logic [7:0]            memory_axi_ar_arlen,
    input  logic [1:0]            memory_axi_ar_arburst,
    input  logic                  memory_axi_ar_arvalid,
    output logic                  memory_axi_ar_arready,
    output logic [M_AXI_ID_W-1:0] memory_axi_r_rid,
    output logic [AXI_DATA_W-1:0] memory_axi_r_rdata,
    output logic [2:0]            memory_axi_r_rresp,
    output logic                  memory_axi_r_rlast,
    output logic                  memory_axi_r_rvalid,
    input  logic                  memory_axi_r_rready
);

    localparam int unsigned OFF_W = $clog2(AXI_STRB_W);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_W-1:0] DEPTH_W = AXI_ADDR_W'(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [2:0] RESP_OKAY   = 3'd0;
    localparam logic [2:0] RESP_SLVERR = 3'd2;
    localparam logic [2:0] RESP_DECERR = 3'd3;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RBurst} r_state_e;

    function automatic logic [AXI_ADDR_W-1:0] next_idx(input logic [AXI_ADDR_W-1:0] idx,
                                                       input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + AXI_ADDR_W'(1);
    endfunction

    logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

    // Write channel state
    w_state_e              w_state_q;
    logic [M_AXI_ID_W-1:0] w_id_q;
    logic [AXI_ADDR_W-1:0] w_idx_q;
    logic [7:0]            w_len_q;
    logic [7:0]            w_cnt_q;
    logic [1:0]            w_burst_q;
    logic                  w_decerr_q;
    logic                  w_slverr_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [M_AXI_ID_W-1:0] bid_q;
    logic [2:0]            bresp_q;

    logic w_beat;
    logic w_in_range;
    logic w_last_beat;
    logic w_decerr_d;
    logic w_slverr_d;

    // wready_q is only ever high in WData, so it qualifies the beat on its own.
    assign w_beat      = wready_q && memory_axi_w_wvalid;
    assign w_in_range  = w_idx_q < DEPTH_W;
    assign w_last_beat = w_cnt_q == w_len_q;
    assign w_decerr_d  = w_decerr_q | ~w_in_range;
    assign w_slverr_d  = w_slverr_q | (memory_axi_w_wlast != w_last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= WIdle;
            w_id_q     <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_burst_q  <= '0;
            w_decerr_q <= 1'b0;
            w_slverr_q <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    awready_q <= 1'b1;
                    if (memory_axi_aw_awvalid && awready_q) begin
                        w_id_q     <= memory_axi_aw_awid;
                        w_idx_q    <= memory_axi_aw_awaddr >> OFF_W;
                        w_len_q    <= memory_axi_aw_awlen;
                        w_burst_q  <= memory_axi_aw_awburst;
                        w_cnt_q    <= '0;
                        w_decerr_q <= 1'b0;
                        w_slverr_q <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        w_state_q  <= WData;
                    end
                end
                WData: begin
                    if (w_beat) begin
                        w_cnt_q    <= w_cnt_q + 8'd1;
                        w_idx_q    <= next_idx(w_idx_q, w_burst_q);
                        w_decerr_q <= w_decerr_d;
                        w_slverr_q <= w_slverr_d;
                        // The beat count alone ends the burst; a stray wlast only flags SLVERR.
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= w_id_q;
                            bresp_q   <= w_decerr_d ? RESP_DECERR :
                                         w_slverr_d ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (memory_axi_b_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_beat && w_in_range) begin
            for (int b = 0; b < int'(AXI_STRB_W); b++) begin
                if (memory_axi_w_wstrb[b]) begin
                    mem[w_idx_q[IDX_W-1:0]][8*b +: 8] <= memory_axi_w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel state
    r_state_e              r_state_q;
    logic [AXI_ADDR_W-1:0] r_idx_q;
    logic [7:0]            r_len_q;
    logic [7:0]            r_cnt_q;
    logic [1:0]            r_burst_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [M_AXI_ID_W-1:0] rid_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [2:0]            rresp_q;

    logic [AXI_ADDR_W-1:0] ar_idx;
    logic [AXI_ADDR_W-1:0] rd_idx;
    logic                  rd_in_range;
    logic [AXI_DATA_W-1:0] rd_word;
    logic [2:0]            rd_resp;

    // The first beat is addressed straight from AR; later beats from the running index.
    assign ar_idx      = memory_axi_ar_araddr >> OFF_W;
    assign rd_idx      = (r_state_q == RIdle) ? ar_idx : r_idx_q;
    assign rd_in_range = rd_idx < DEPTH_W;
    assign rd_word     = rd_in_range ? mem[rd_idx[IDX_W-1:0]] : '0;
    assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_DECERR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    arready_q <= 1'b1;
                    if (memory_axi_ar_arvalid && arready_q) begin
                        rid_q     <= memory_axi_ar_arid;
                        r_len_q   <= memory_axi_ar_arlen;
                        r_burst_q <= memory_axi_ar_arburst;
                        r_idx_q   <= next_idx(ar_idx, memory_axi_ar_arburst);
                        r_cnt_q   <= 8'd1;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_word;
                        rresp_q   <= rd_resp;
                        rlast_q   <= memory_axi_ar_arlen == 8'd0;
                        r_state_q <= RBurst;
                    end
                end
                RBurst: begin
                    if (rvalid_q && memory_axi_r_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= RIdle;
                        end else begin
                            rdata_q <= rd_word;
                            rresp_q <= rd_resp;
                            rlast_q <= r_cnt_q == r_len_q;
                            r_cnt_q <= r_cnt_q + 8'd1;
                            r_idx_q <= next_idx(r_idx_q, r_burst_q);
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    assign memory_axi_aw_awready = awready_q;
    assign memory_axi_w_wready   = wready_q;
    assign memory_axi_b_bvalid   = bvalid_q;
    assign memory_axi_b_bid      = bid_q;
    assign memory_axi_b_bresp    = bresp_q;
    assign memory_axi_ar_arready = arready_q;
    assign memory_axi_r_rvalid   = rvalid_q;
    assign memory_axi_r_rlast    = rlast_q;
    assign memory_axi_r_rid      = rid_q;
    assign memory_axi_r_rdata    = rdata_q;
    assign memory_axi_r_rresp    = rresp_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized self-checking bench for axi_ram_responder against a byte-level memory model
// that also tracks which bytes have ever been written.
module tb_axi_ram_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [5:0]  bid;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [5:0]  rid;
    logic [63:0] rdata;
    logic [2:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi_ram_responder dut (
        .clk                   (clk),
        .rst                   (rst),
        .memory_axi_aw_awid    (awid),
        .memory_axi_aw_awaddr  (awaddr),
        .memory_axi_aw_awlen   (awlen),
        .memory_axi_aw_awburst (awburst),
        .memory_axi_aw_awvalid (awvalid),
        .memory_axi_aw_awready (awready),
        .memory_axi_w_wdata    (wdata),
        .memory_axi_w_wstrb    (wstrb),
        .memory_axi_w_wlast    (wlast),
        .memory_axi_w_wvalid   (wvalid),
        .memory_axi_w_wready   (wready),
        .memory_axi_b_bid      (bid),
        .memory_axi_b_bresp    (bresp),
        .memory_axi_b_bvalid   (bvalid),
        .memory_axi_b_bready   (bready),
        .memory_axi_ar_arid    (arid),
        .memory_axi_ar_araddr  (araddr),
        .memory_axi_ar_arlen   (arlen),
        .memory_axi_ar_arburst (arburst),
        .memory_axi_ar_arvalid (arvalid),
        .memory_axi_ar_arready (arready),
        .memory_axi_r_rid      (rid),
        .memory_axi_r_rdata    (rdata),
        .memory_axi_r_rresp    (rresp),
        .memory_axi_r_rlast    (rlast),
        .memory_axi_r_rvalid   (rvalid),
        .memory_axi_r_rready   (rready)
    );

    int checks = 0;
    int errors = 0;

    bit [63:0] model_mem [DEPTH];
    bit [7:0]  known [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] byte_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    function automatic logic [31:0] beat_idx(input logic [31:0] addr, input logic [1:0] burst,
                                             input int i);
        return (burst == 2'd0) ? (addr >> 3) : (addr >> 3) + 32'(i);
    endfunction

    task automatic model_write(input logic [31:0] idx, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) begin
                model_mem[idx[9:0]][8*b +: 8] = d[8*b +: 8];
                known[idx[9:0]][b] = 1'b1;
            end
        end
    endtask

    task automatic do_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, output bit ok);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        ok = awready;
        if (!ok) check_val("aw_handshake", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    // Sends beat i; returns the wlast actually driven so the caller can model SLVERR.
    task automatic do_w(input int i, input logic [7:0] len, input int bad_beat, output bit ok,
                        output bit sent_last);
        int n = 0;
        wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
        wlast = ((i == int'(len)) != (i == bad_beat));
        sent_last = wlast;
        while (!wready && n < 50) begin tick(); n++; end
        ok = wready;
        if (!ok) check_val("w_handshake", wready, 1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int bad_beat, input bit gaps);
        bit ok, sl, dec = 0, slv = 0;
        logic [31:0] idx;
        logic [2:0] exp_resp;
        int n = 0;
        do_aw(id, addr, len, burst, ok);
        if (!ok) return;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) tick();
            do_w(i, len, bad_beat, ok, sl);
            if (!ok) return;
            if (sl != (i == int'(len))) slv = 1;
            idx = beat_idx(addr, burst, i);
            if (idx < DEPTH) model_write(idx, wd[i], ws[i]);
            else dec = 1;
        end
        exp_resp = dec ? 3'd3 : (slv ? 3'd2 : 3'd0);
        while (!bvalid && n < 50) begin tick(); n++; end
        check_val("b_valid", bvalid, 1);
        if (!bvalid) return;
        repeat ($urandom_range(0, 3)) tick();
        check_val("b_id", bid, id);
        check_val("b_resp", bresp, exp_resp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_val("b_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle);
        int n = 0, beat = 0, cyc = 0;
        bit stalled = 0;
        logic [63:0] held = '0, m, exp_d;
        logic [31:0] idx;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) begin
            check_val("ar_handshake", arready, 1);
            arvalid = 1'b0;
            return;
        end
        tick();
        arvalid = 1'b0;
        check_val("r_first_latency", rvalid, 1);
        while (beat <= int'(len) && cyc < 2000) begin
            if (stalled) check_val("r_hold", rdata, held);
            rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid && rready) begin
                idx = beat_idx(addr, burst, beat);
                if (idx < DEPTH) begin
                    m = byte_mask(known[idx[9:0]]);
                    exp_d = model_mem[idx[9:0]];
                    check_val("r_resp", rresp, 0);
                end else begin
                    m = '1;
                    exp_d = '0;
                    check_val("r_resp", rresp, 3);
                end
                check_val("r_data", rdata & m, exp_d & m);
                check_val("r_last", rlast, beat == int'(len));
                check_val("r_id", rid, id);
                beat++;
                stalled = 0;
            end else begin
                stalled = rvalid;
                held = rdata;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        check_val("r_beats", beat, int'(len) + 1);
        if (!toggle) check_val("r_cycles", cyc, int'(len) + 1);
        check_val("r_idle_arready", arready, 1);
        check_val("r_idle_rvalid", rvalid, 0);
    endtask

    initial begin
        bit ok, sl;
        logic [31:0] a;

        repeat (3) tick();
        check_val("rst_awready", awready, 0);
        check_val("rst_wready", wready, 0);
        check_val("rst_bvalid", bvalid, 0);
        check_val("rst_arready", arready, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_rlast", rlast, 0);
        rst = 1'b0;
        tick();
        check_val("post_rst_awready", awready, 1);
        check_val("post_rst_arready", arready, 1);

        // Basic INCR write then back-to-back read
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
        axi_write(6'd5, 32'h40, 8'd3, 2'd1, -1, 1'b0);
        axi_read(6'd2, 32'h40, 8'd3, 2'd1, 1'b0);

        // Partial strobe merges into an existing word
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        axi_write(6'd1, 32'h0, 8'd0, 2'd1, -1, 1'b0);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        axi_write(6'd1, 32'h0, 8'd0, 2'd1, -1, 1'b0);
        check_val("strb_model", model_mem[0], 64'hFFFF_FFFF_0000_0000);
        axi_read(6'd3, 32'h0, 8'd0, 2'd1, 1'b0);

        // FIXED burst: last beat wins
        wd[0] = 64'hAAAA_0000_AAAA_0001; wd[1] = 64'hBBBB_0000_BBBB_0002;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        axi_write(6'd9, 32'h8, 8'd1, 2'd0, -1, 1'b0);
        axi_read(6'd4, 32'h8, 8'd0, 2'd1, 1'b0);

        // Top of memory: second beat runs off the end
        wd[0] = 64'h1234_5678_9ABC_DEF0; ws[0] = 8'hFF;
        axi_write(6'd2, DEPTH * 8 - 8, 8'd0, 2'd1, -1, 1'b0);
        axi_read(6'd6, DEPTH * 8 - 8, 8'd1, 2'd1, 1'b0);

        // Early wlast, then a stalled read
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(6'd10, 32'h80, 8'd2, 2'd1, 1, 1'b0);
        axi_read(6'd11, 32'h80, 8'd3, 2'd1, 1'b1);

        // Reset in the middle of a write burst
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(6'd12, 32'h100, 8'd3, 2'd1, -1, 1'b0);
        for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
        do_aw(6'd13, 32'h100, 8'd3, 2'd1, ok);
        for (int i = 0; i < 2; i++) begin
            do_w(i, 8'd3, -1, ok, sl);
            model_write(32'h20 + 32'(i), wd[i], ws[i]);
        end
        wvalid = 1'b1; wdata = wd[2]; wstrb = 8'hFF;
        rst = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check_val("midrst_bvalid", bvalid, 0);
        check_val("midrst_awready", awready, 0);
        rst = 1'b0;
        tick();
        check_val("midrst_awready_after", awready, 1);
        for (int i = 0; i < 4; i++) begin
            check_val("midrst_no_b", bvalid, 0);
            tick();
        end
        axi_read(6'd14, 32'h100, 8'd3, 2'd1, 1'b0);

        // Random traffic, including bursts that cross the top of memory
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) a = (DEPTH - 4 + $urandom_range(0, 3)) * 8;
            else a = $urandom_range(0, 63) * 8;
            a = a + $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                wd[i] = {$urandom, $urandom};
                ws[i] = 8'($urandom);
            end
            axi_write(6'($urandom), a, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1, 1'b1);
            if ($urandom_range(0, 4) == 0) a = (DEPTH - 4 + $urandom_range(0, 3)) * 8;
            else a = $urandom_range(0, 63) * 8;
            axi_read(6'($urandom), a, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
